wave_rom_arbiter: RTL and testbench

//   Shares one single-port waveform ROM (DATA_W x 2**ADDR_W, registered, rden-gated)

---
 rtl/wave_rom_arbiter.sv | 81 ++++++++
 tb/tb_wave_rom_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_rom_arbiter.sv
// Two-channel round-robin front end for one registered, rden-gated waveform ROM.
// Each issued read carries a channel tag through the ROM pipeline so its data returns to the right requester.
module wave_rom_arbiter #(
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ROM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_a,
   input  logic [ADDR_W-1:0] addr_a,
   output logic              gnt_a,
   output logic              rd_valid_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic              req_b,
   input  logic [ADDR_W-1:0] addr_b,
   output logic              gnt_b,
   output logic              rd_valid_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic [ADDR_W-1:0] rom_address,
   output logic              rom_rden,
   input  logic [DATA_W-1:0] rom_q
);

   localparam int unsigned NStages = ROM_LAT + 1;

   logic               last_b_q, last_b_d;
   logic               grant;
   logic               ret_a, ret_b;
   logic [ADDR_W-1:0]  addr_d;
   logic [NStages-1:0] tag_vld_q, tag_vld_d;
   logic [NStages-1:0] tag_chb_q, tag_chb_d;

   // On contention the channel that did not win last time gets the slot.
   always_comb begin
      gnt_a    = req_a & (~req_b | last_b_q);
      gnt_b    = req_b & ~gnt_a;
      grant    = gnt_a | gnt_b;
      last_b_d = grant ? gnt_b : last_b_q;
      addr_d   = gnt_b ? addr_b : (gnt_a ? addr_a : rom_address);
   end

   // Tag bit k describes the read issued k+1 cycles ago; bit ROM_LAT lines up with rom_q.
   always_comb begin
      tag_vld_d = {tag_vld_q[NStages-2:0], grant};
      tag_chb_d = {tag_chb_q[NStages-2:0], gnt_b};
      ret_a     = tag_vld_q[ROM_LAT] & ~tag_chb_q[ROM_LAT];
      ret_b     = tag_vld_q[ROM_LAT] & tag_chb_q[ROM_LAT];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_b_q    <= 1'b1;
         tag_vld_q   <= '0;
         tag_chb_q   <= '0;
         rom_address <= '0;
         rom_rden    <= 1'b0;
      end else begin
         last_b_q    <= last_b_d;
         tag_vld_q   <= tag_vld_d;
         tag_chb_q   <= tag_chb_d;
         rom_address <= addr_d;
         rom_rden    <= grant;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_a <= 1'b0;
         rd_valid_b <= 1'b0;
         rd_data_a  <= '0;
         rd_data_b  <= '0;
      end else begin
         rd_valid_a <= ret_a;
         rd_valid_b <= ret_b;
         if (ret_a) rd_data_a <= rom_q;
         if (ret_b) rd_data_b <= rom_q;
      end
   end

endmodule

// File: tb/tb_wave_rom_arbiter.sv
// Bench for wave_rom_arbiter: behavioural ROM, grant vector table, scoreboarded read returns.
module tb_wave_rom_arbiter;

   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ROM_LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_a, req_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic              gnt_a, gnt_b;
   logic              rd_valid_a, rd_valid_b;
   logic [DATA_W-1:0] rd_data_a, rd_data_b;
   logic [ADDR_W-1:0] rom_address;
   logic              rom_rden;
   logic [DATA_W-1:0] rom_q;
   logic [DATA_W-1:0] rom_s1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int vcount = 0;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                due;
   } exp_t;
   exp_t qa[$];
   exp_t qb[$];
   exp_t e;

   typedef struct {
      logic              ra;
      logic [ADDR_W-1:0] aa;
      logic              rb;
      logic [ADDR_W-1:0] ab;
      logic              ga;
      logic              gb;
   } vec_t;
   vec_t vt[9];

   logic              prev_g;
   logic [ADDR_W-1:0] prev_addr;
   logic [ADDR_W-1:0] last_addr;

   wave_rom_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .ROM_LAT(ROM_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_a      (req_a),
      .addr_a     (addr_a),
      .gnt_a      (gnt_a),
      .rd_valid_a (rd_valid_a),
      .rd_data_a  (rd_data_a),
      .req_b      (req_b),
      .addr_b     (addr_b),
      .gnt_b      (gnt_b),
      .rd_valid_b (rd_valid_b),
      .rd_data_b  (rd_data_b),
      .rom_address(rom_address),
      .rom_rden   (rom_rden),
      .rom_q      (rom_q)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
      logic [7:0] m;
      m = a[7:0] * 8'd29;
      return (m + {2'b00, a[13:8]}) ^ 8'h5A;
   endfunction

   // Two-edge registered ROM, output only advances its first stage when rden is high.
   always @(posedge clk) begin
      if (rom_rden) rom_s1 <= rom_fn(rom_address);
      rom_q <= rom_s1;
      cyc   <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         prev_g    = 1'b0;
         last_addr = '0;
         chk("reset rd_valid_a", rd_valid_a, 0);
         chk("reset rd_valid_b", rd_valid_b, 0);
         chk("reset rd_data_a", rd_data_a, 0);
         chk("reset rd_data_b", rd_data_b, 0);
         chk("reset rom_rden", rom_rden, 0);
         chk("reset rom_address", rom_address, 0);
      end else begin
         if (rd_valid_a) begin
            vcount++;
            if (qa.size() == 0) chk("spurious rd_valid_a", 1, 0);
            else begin
               e = qa.pop_front();
               chk("rd_data_a", rd_data_a, e.data);
               chk("latency_a", cyc, e.due);
            end
         end else if (qa.size() > 0 && qa[0].due <= cyc) begin
            chk("missing rd_valid_a", 0, 1);
            void'(qa.pop_front());
         end
         if (rd_valid_b) begin
            vcount++;
            if (qb.size() == 0) chk("spurious rd_valid_b", 1, 0);
            else begin
               e = qb.pop_front();
               chk("rd_data_b", rd_data_b, e.data);
               chk("latency_b", cyc, e.due);
            end
         end else if (qb.size() > 0 && qb[0].due <= cyc) begin
            chk("missing rd_valid_b", 0, 1);
            void'(qb.pop_front());
         end
         chk("rom_rden", rom_rden, prev_g);
         if (prev_g) last_addr = prev_addr;
         chk("rom_address", rom_address, last_addr);
         chk("gnt exclusive", gnt_a & gnt_b, 0);
         chk("gnt_a without req", gnt_a & ~req_a, 0);
         chk("gnt_b without req", gnt_b & ~req_b, 0);
         prev_g    = gnt_a | gnt_b;
         prev_addr = gnt_a ? addr_a : addr_b;
         if (gnt_a) qa.push_back('{data: rom_fn(addr_a), due: cyc + 2 + ROM_LAT});
         if (gnt_b) qb.push_back('{data: rom_fn(addr_b), due: cyc + 2 + ROM_LAT});
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req_a = 1'b0;
      req_b = 1'b0;
      repeat (n) next_cycle();
   endtask

   task automatic do_reset();
      req_a = 1'b0;
      req_b = 1'b0;
      rst_n = 1'b0;
      repeat (2) next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      int nb;
      int vbase;
      rst_n  = 1'b0;
      req_a  = 1'b0;
      req_b  = 1'b0;
      addr_a = '0;
      addr_b = '0;
      // Starts with last grant = A (after test 1): row 0 A only.
      vt[0] = '{1'b1, 14'h0001, 1'b0, 14'h0000, 1'b1, 1'b0};
      vt[1] = '{1'b1, 14'h0002, 1'b1, 14'h0101, 1'b0, 1'b1};
      vt[2] = '{1'b1, 14'h0002, 1'b1, 14'h0102, 1'b1, 1'b0};
      vt[3] = '{1'b0, 14'h0000, 1'b1, 14'h0102, 1'b0, 1'b1};
      vt[4] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0, 1'b0};
      vt[5] = '{1'b1, 14'h0003, 1'b1, 14'h0103, 1'b1, 1'b0};
      vt[6] = '{1'b1, 14'h0004, 1'b0, 14'h0000, 1'b1, 1'b0};
      vt[7] = '{1'b1, 14'h0005, 1'b1, 14'h0103, 1'b0, 1'b1};
      vt[8] = '{1'b1, 14'h0005, 1'b0, 14'h0000, 1'b1, 1'b0};
      repeat (2) next_cycle();
      rst_n = 1'b1;

      // 1: single A read
      req_a  = 1'b1;
      addr_a = 14'h0010;
      @(negedge clk);
      chk("t1 gnt_a", gnt_a, 1);
      next_cycle();
      req_a = 1'b0;
      @(negedge clk);
      chk("t1 rom_address", rom_address, 14'h0010);
      chk("t1 rom_rden", rom_rden, 1);
      next_cycle();
      idle(6);

      // Grant vector table
      for (int i = 0; i < 9; i++) begin
         req_a  = vt[i].ra;
         addr_a = vt[i].aa;
         req_b  = vt[i].rb;
         addr_b = vt[i].ab;
         @(negedge clk);
         chk($sformatf("vec%0d gnt_a", i), gnt_a, vt[i].ga);
         chk($sformatf("vec%0d gnt_b", i), gnt_b, vt[i].gb);
         next_cycle();
      end
      idle(8);

      // 2: both requesting right after reset
      do_reset();
      req_a  = 1'b1;
      addr_a = 14'h0100;
      req_b  = 1'b1;
      addr_b = 14'h2000;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("t2 gnt_a[%0d]", i), gnt_a, (i % 2) == 0);
         chk($sformatf("t2 gnt_b[%0d]", i), gnt_b, (i % 2) == 1);
         next_cycle();
      end
      idle(8);

      // 3: A streams addresses 0..15
      vbase = vcount;
      for (int i = 0; i < 16; i++) begin
         req_a  = 1'b1;
         addr_a = ADDR_W'(i);
         @(negedge clk);
         chk($sformatf("t3 gnt_a[%0d]", i), gnt_a, 1);
         next_cycle();
      end
      idle(8);
      chk("t3 rd_valid count", vcount - vbase, 16);

      // 4: address wrap
      for (int i = 0; i < 3; i++) begin
         req_a  = 1'b1;
         addr_a = 14'h3FFE + ADDR_W'(i);
         @(negedge clk);
         chk($sformatf("t4 gnt_a[%0d]", i), gnt_a, 1);
         next_cycle();
      end
      req_a = 1'b0;
      @(negedge clk);
      chk("t4 rom_address wrap", rom_address, 14'h0000);
      next_cycle();
      idle(8);

      // 5: reset with three reads in flight
      for (int i = 0; i < 3; i++) begin
         req_a  = 1'b1;
         addr_a = 14'h0055 + ADDR_W'(i);
         next_cycle();
      end
      do_reset();
      vbase = vcount;
      idle(8);
      chk("t5 no rd_valid after reset", vcount - vbase, 0);
      req_a  = 1'b1;
      addr_a = 14'h0077;
      req_b  = 1'b1;
      addr_b = 14'h0088;
      @(negedge clk);
      chk("t5 first contention gnt_a", gnt_a, 1);
      chk("t5 first contention gnt_b", gnt_b, 0);
      next_cycle();
      req_a = 1'b0;
      @(negedge clk);
      chk("t5 b after a", gnt_b, 1);
      next_cycle();
      idle(8);

      // 6: B held, A pulses every third cycle
      do_reset();
      nb = 0;
      vbase = vcount;
      for (int i = 0; i < 12; i++) begin
         req_b  = 1'b1;
         addr_b = 14'h1000 + ADDR_W'(nb);
         req_a  = (i % 3) == 0;
         addr_a = 14'h0200 + ADDR_W'(i);
         @(negedge clk);
         chk($sformatf("t6 gnt_a[%0d]", i), gnt_a, (i % 3) == 0);
         chk($sformatf("t6 gnt_b[%0d]", i), gnt_b, (i % 3) != 0);
         if (gnt_b) nb++;
         next_cycle();
      end
      idle(10);
      chk("t6 returns", vcount - vbase, 12);

      chk("queue a drained", qa.size(), 0);
      chk("queue b drained", qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
